// File: rtl/dpram_port_arbiter.sv
// Purpose: arbitrates three requesters (image buffer, hash calc, reordering)
// onto one single-port RAM. Round-robin grant from IDLE, burst ownership
// with a forced release after MAX_BURST accesses when another requester
// is waiting, and a one-cycle read-valid strobe back to the owner.
//
// Ports:
//   clk                  sole clock, rising edge
//   reset                synchronous, active-low
//   req[2:0]             access request (0=image buffer, 1=hash, 2=reorder)
//   addr0..addr2         requester RAM addresses
//   wdata0..wdata2       requester write data
//   web[2:0]             requester write enable, active-low (0=write)
//   gnt[2:0]             registered one-hot ownership grant
//   rvalid[2:0]          registered one-hot read-data-valid strobe
//   mem_A, mem_I         RAM address / write data (combinational from owner)
//   mem_WEB/CSB/OEB      RAM strobes, active-low (combinational from owner)
//   busy                 registered, high while a requester owns the RAM

module dpram_port_arbiter #(
    parameter int unsigned MAX_BURST = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [11:0] addr0,
    input  logic [11:0] addr1,
    input  logic [11:0] addr2,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [31:0] wdata2,
    input  logic [2:0]  web,
    output logic [2:0]  gnt,
    output logic [2:0]  rvalid,
    output logic [11:0] mem_A,
    output logic [31:0] mem_I,
    output logic        mem_WEB,
    output logic        mem_CSB,
    output logic        mem_OEB,
    output logic        busy
);

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 2;

    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   burst_q;

    // Next requester index in round-robin order, wrapping 2 -> 0.
    function automatic logic [IDX_W-1:0] inc3(input logic [IDX_W-1:0] i);
        logic [IDX_W-1:0] r;
        case (i)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Index-to-one-hot; the unused index 3 maps to no requester.
    function automatic logic [2:0] onehot(input logic [IDX_W-1:0] i);
        logic [2:0] r;
        case (i)
            2'd0:    r = 3'b001;
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Select one bit of a per-requester vector by requester index.
    function automatic logic bit_of(input logic [2:0] v, input logic [IDX_W-1:0] i);
        logic r;
        case (i)
            2'd0:    r = v[0];
            2'd1:    r = v[1];
            2'd2:    r = v[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [IDX_W-1:0] cand0_c;
    logic [IDX_W-1:0] cand1_c;
    logic [IDX_W-1:0] cand2_c;
    logic [IDX_W-1:0] winner_c;
    logic             owner_req_c;
    logic             owner_web_c;
    logic [2:0]       others_c;
    logic             access_c;
    logic             release_c;

    // Round-robin winner: first requesting index at or above the pointer.
    always_comb begin
        cand0_c  = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
        cand1_c  = inc3(cand0_c);
        cand2_c  = inc3(cand1_c);
        winner_c = cand2_c;
        if (bit_of(req, cand0_c)) begin
            winner_c = cand0_c;
        end else if (bit_of(req, cand1_c)) begin
            winner_c = cand1_c;
        end
    end

    // Access and release decisions for the current owner.
    always_comb begin
        owner_req_c = bit_of(req, owner_q);
        owner_web_c = bit_of(web, owner_q);
        others_c    = req & ~onehot(owner_q);
        access_c    = (state_q == OWNED) && owner_req_c;
        // A forced release still lets this cycle's access complete.
        release_c   = (state_q == OWNED) &&
                      (!owner_req_c || ((burst_q == BURST_LAST) && (|others_c)));
    end

    // RAM port drive: owner's signals during an access, inactive otherwise.
    always_comb begin
        mem_A   = ADDR_W'(0);
        mem_I   = DATA_W'(0);
        mem_WEB = 1'b1;
        mem_CSB = 1'b1;
        mem_OEB = 1'b1;
        if (access_c) begin
            case (owner_q)
                2'd0: begin
                    mem_A = addr0;
                    mem_I = wdata0;
                end
                2'd1: begin
                    mem_A = addr1;
                    mem_I = wdata1;
                end
                2'd2: begin
                    mem_A = addr2;
                    mem_I = wdata2;
                end
                default: begin
                    mem_A = ADDR_W'(0);
                    mem_I = DATA_W'(0);
                end
            endcase
            mem_WEB = owner_web_c;
            mem_CSB = 1'b0;
            mem_OEB = 1'b0;
        end
    end

    // Arbitration FSM with registered grant, busy and read-valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            burst_q <= CNT_W'(0);
            gnt     <= 3'b000;
            rvalid  <= 3'b000;
            busy    <= 1'b0;
        end else begin
            // Read data is valid the cycle after a read access.
            rvalid <= (access_c && owner_web_c) ? onehot(owner_q) : 3'b000;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= OWNED;
                        owner_q <= winner_c;
                        gnt     <= onehot(winner_c);
                        busy    <= 1'b1;
                        burst_q <= CNT_W'(0);
                    end
                end
                OWNED: begin
                    if (burst_q != CNT_SAT) begin
                        burst_q <= burst_q + CNT_W'(1);
                    end
                    // Release always passes through IDLE, giving one bubble.
                    if (release_c) begin
                        state_q <= IDLE;
                        gnt     <= 3'b000;
                        busy    <= 1'b0;
                        ptr_q   <= inc3(owner_q);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// transaction-level model of the arbitration rules.

module tb_dpram_port_arbiter;

    localparam int unsigned MAX_BURST = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  web;
    logic [11:0] ta [3];
    logic [31:0] td [3];
    logic [11:0] addr0, addr1, addr2;
    logic [31:0] wdata0, wdata1, wdata2;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [11:0] mem_A;
    logic [31:0] mem_I;
    logic        mem_WEB, mem_CSB, mem_OEB;
    logic        busy;

    assign addr0  = ta[0];
    assign addr1  = ta[1];
    assign addr2  = ta[2];
    assign wdata0 = td[0];
    assign wdata1 = td[1];
    assign wdata2 = td[2];

    always #5 clk = ~clk;

    dpram_port_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .addr0  (addr0),
        .addr1  (addr1),
        .addr2  (addr2),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .wdata2 (wdata2),
        .web    (web),
        .gnt    (gnt),
        .rvalid (rvalid),
        .mem_A  (mem_A),
        .mem_I  (mem_I),
        .mem_WEB(mem_WEB),
        .mem_CSB(mem_CSB),
        .mem_OEB(mem_OEB),
        .busy   (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: owner index or -1 when nobody owns, next-preferred requester,
    // accesses-so-far in the burst, and who gets read data next cycle (-1 none).
    int m_owner;
    int m_ptr;
    int m_run;
    int m_rv;

    // Values seen by the last step, for scenario-level checks.
    logic [2:0]  s_gnt;
    logic        s_csb;
    logic        s_web;
    logic [11:0] s_a;
    logic [31:0] s_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Called right after inputs are driven (at a falling edge): compare every
    // output against the model, advance the model across the coming rising
    // edge, and return at the next falling edge.
    task automatic step();
        bit         acc;
        logic [2:0] oth;
        int         w;
        int         c;
        #1;
        acc   = (m_owner >= 0) && (req[m_owner] == 1'b1);
        s_gnt = gnt;
        s_csb = mem_CSB;
        s_web = mem_WEB;
        s_a   = mem_A;
        s_i   = mem_I;
        chk("gnt",     64'(gnt),     64'((m_owner < 0) ? 3'b000 : 3'(1 << m_owner)));
        chk("busy",    64'(busy),    64'(m_owner >= 0));
        chk("rvalid",  64'(rvalid),  64'((m_rv < 0) ? 3'b000 : 3'(1 << m_rv)));
        chk("mem_CSB", 64'(mem_CSB), 64'(!acc));
        chk("mem_OEB", 64'(mem_OEB), 64'(!acc));
        chk("mem_WEB", 64'(mem_WEB), 64'(acc ? web[m_owner] : 1'b1));
        chk("mem_A",   64'(mem_A),   64'(acc ? ta[m_owner] : 12'h000));
        chk("mem_I",   64'(mem_I),   64'(acc ? td[m_owner] : 32'h0));
        chk("gnt_onehot", 64'($countones(gnt) <= 1), 64'(1));

        if (reset == 1'b0) begin
            m_owner = -1; m_ptr = 0; m_run = 0; m_rv = -1;
        end else if (m_owner < 0) begin
            m_rv = -1;
            w = -1;
            for (int i = 0; i < 3; i++) begin
                c = (m_ptr + i) % 3;
                if (w < 0 && req[c] == 1'b1) w = c;
            end
            if (w >= 0) begin
                m_owner = w;
                m_run   = 0;
            end
        end else begin
            m_rv = (acc && web[m_owner] == 1'b1) ? m_owner : -1;
            oth  = req & ~3'(1 << m_owner);
            if (!acc || (m_run == int'(MAX_BURST) - 1 && oth != 3'b000)) begin
                m_ptr   = (m_owner + 1) % 3;
                m_owner = -1;
            end
            m_run = (m_run < 255) ? m_run + 1 : 255;
        end
        @(negedge clk);
    endtask

    initial begin
        int nacc;
        int nidle;
        reset = 1'b0;
        req   = 3'b000;
        web   = 3'b111;
        for (int i = 0; i < 3; i++) begin
            ta[i] = 12'h000;
            td[i] = 32'h0;
        end
        m_owner = -1; m_ptr = 0; m_run = 0; m_rv = -1;
        @(negedge clk);
        @(negedge clk);

        // Reset state, then round-robin from pointer 0 and after a release.
        chk("reset_gnt", 64'(gnt), 64'(3'b000));
        chk("reset_busy", 64'(busy), 64'(0));
        reset = 1'b1;
        req = 3'b110; step();
        chk("rr_first_gnt", 64'(gnt), 64'(3'b010));
        req = 3'b000; step();
        chk("rr_release_gnt", 64'(gnt), 64'(3'b000));
        req = 3'b101; step();
        chk("rr_second_gnt", 64'(gnt), 64'(3'b100));
        req = 3'b000; step();
        step();

        // Owner 0 single read: address same cycle, rvalid next cycle only.
        ta[0] = 12'h010; web = 3'b111;
        req = 3'b001; step();
        chk("rd_gnt", 64'(gnt), 64'(3'b001));
        step();
        chk("rd_mem_A", 64'(s_a), 64'(12'h010));
        chk("rd_mem_CSB", 64'(s_csb), 64'(0));
        chk("rd_rvalid", 64'(rvalid), 64'(3'b001));
        req = 3'b000; step();
        chk("rd_rvalid_once", 64'(rvalid), 64'(3'b000));

        // Forced release: owner 1 capped at MAX_BURST accesses while 2 waits.
        req = 3'b110; step();
        chk("burst_gnt", 64'(gnt), 64'(3'b010));
        nacc = 0; nidle = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (s_gnt == 3'b010 && s_csb == 1'b0) nacc++;
            if (s_gnt == 3'b000) nidle++;
        end
        chk("burst_accesses", 64'(nacc), 64'(64));
        chk("burst_idle", 64'(nidle), 64'(1));
        chk("burst_next_gnt", 64'(gnt), 64'(3'b100));

        // Owner 2 writes at the top address, then drops its request.
        ta[2] = 12'hFFF; td[2] = 32'hDEADBEEF; web = 3'b011;
        req = 3'b100; step();
        chk("wr_mem_WEB", 64'(s_web), 64'(0));
        chk("wr_mem_A", 64'(s_a), 64'(12'hFFF));
        chk("wr_mem_I", 64'(s_i), 64'(32'hDEADBEEF));
        chk("wr_no_rvalid", 64'(rvalid), 64'(3'b000));
        req = 3'b000; step();
        chk("wr_drop_WEB", 64'(s_web), 64'(1));
        chk("wr_drop_gnt", 64'(gnt), 64'(3'b000));
        chk("wr_drop_rvalid", 64'(rvalid), 64'(3'b000));

        // Reset during a read burst, then requester 0 wins first.
        web = 3'b111;
        req = 3'b001; step();
        step();
        step();
        reset = 1'b0; step();
        chk("rst_gnt", 64'(gnt), 64'(3'b000));
        chk("rst_rvalid", 64'(rvalid), 64'(3'b000));
        chk("rst_busy", 64'(busy), 64'(0));
        reset = 1'b1; req = 3'b111; step();
        chk("rst_first_gnt", 64'(gnt), 64'(3'b001));

        // Randomized traffic: alternating sparse and sticky request segments.
        for (int seg = 0; seg < 8; seg++) begin
            int mode;
            mode = int'($urandom_range(0, 1));
            for (int k = 0; k < 250; k++) begin
                for (int i = 0; i < 3; i++) begin
                    ta[i] = 12'($urandom);
                    td[i] = $urandom;
                    if (mode == 1) req[i] = ($urandom_range(0, 39) != 0);
                    else           req[i] = 1'($urandom);
                end
                web   = 3'($urandom);
                reset = ($urandom_range(0, 299) != 0);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
